// File: rtl/seq_entry_display_if.sv
// Signal bundle for seq_entry_display.
//   display       round selector (starts a round on TRIGGER_CODE)
//   one_sec       one-cycle pulse per second
//   sequence_in   target sequence, one one-hot-low nibble per digit
//   button_*      debounced level buttons, active-high
//   sevseg        active-low segment patterns, 7 bits per digit
//   sequence_out  entered sequence, same nibble encoding as sequence_in
//   cursor        index of the digit being edited
//   done          one-cycle pulse when entry completes
//   match         registered comparison result of the last completed entry
// master: the environment driving the block; slave: seq_entry_display itself.
interface seq_entry_display_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [7:0]              display;
    logic                    one_sec;
    logic [4*NUM_DIGITS-1:0] sequence_in;
    logic                    button_move;
    logic                    button_next;
    logic                    button_back;
    logic [7*NUM_DIGITS-1:0] sevseg;
    logic [4*NUM_DIGITS-1:0] sequence_out;
    logic [2:0]              cursor;
    logic                    done;
    logic                    match;

    modport master (
        output display, one_sec, sequence_in, button_move, button_next, button_back,
        input  sevseg, sequence_out, cursor, done, match
    );

    modport slave (
        input  display, one_sec, sequence_in, button_move, button_next, button_back,
        output sevseg, sequence_out, cursor, done, match
    );
endinterface

// File: rtl/seq_entry_display.sv
// Sequence memory game: shows a target sequence for SHOW_SECONDS seconds,
// then lets the player enter it digit by digit with three buttons and
// reports whether the entry matched.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low reset
//   bus    seq_entry_display_if.slave (display, one_sec, sequence_in,
//          buttons in; sevseg, sequence_out, cursor, done, match out)
module seq_entry_display #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SHOW_SECONDS = 2,
    parameter logic [7:0]  TRIGGER_CODE = 8'h10
) (
    input logic              clk,
    input logic              reset,
    seq_entry_display_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(SHOW_SECONDS + 1);

    typedef enum logic [2:0] {IDLE, SHOW, ENTRY_INIT, ENTRY, CHECK} state_t;

    state_t                  state, state_d;
    logic [CNT_W-1:0]        show_cnt, show_cnt_d;
    logic [4*NUM_DIGITS-1:0] seq_q, seq_d;
    logic [2:0]              cursor_q, cursor_d;
    logic                    match_q, match_d;
    logic                    done_c;
    logic [7*NUM_DIGITS-1:0] seg_c;
    logic [2:0]              btn, btn_q, btn_edge;

    function automatic logic [6:0] seg_map(input logic [3:0] code);
        case (code)
            4'b1110: seg_map = 7'b1111110;
            4'b1101: seg_map = 7'b1111001;
            4'b1011: seg_map = 7'b1110111;
            4'b0111: seg_map = 7'b1001111;
            default: seg_map = 7'b0100001;
        endcase
    endfunction

    // {move, next, back}; the history runs in every state so a button held
    // while entering ENTRY does not register as a fresh press.
    assign btn      = {bus.button_move, bus.button_next, bus.button_back};
    assign btn_edge = btn & ~btn_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            show_cnt <= '0;
            seq_q    <= {NUM_DIGITS{4'b1110}};
            cursor_q <= '0;
            match_q  <= 1'b0;
            btn_q    <= '0;
        end else begin
            state    <= state_d;
            show_cnt <= show_cnt_d;
            seq_q    <= seq_d;
            cursor_q <= cursor_d;
            match_q  <= match_d;
            btn_q    <= btn;
        end
    end

    always_comb begin
        state_d    = state;
        show_cnt_d = show_cnt;
        seq_d      = seq_q;
        cursor_d   = cursor_q;
        match_d    = match_q;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                show_cnt_d = '0;
                if (bus.display == TRIGGER_CODE) state_d = SHOW;
            end
            SHOW: begin
                if (bus.one_sec) begin
                    show_cnt_d = show_cnt + CNT_W'(1);
                    // Entry values are loaded on the way in so that the
                    // ENTRY_INIT cycle already presents them.
                    if (show_cnt == CNT_W'(SHOW_SECONDS - 1)) begin
                        state_d  = ENTRY_INIT;
                        seq_d    = {NUM_DIGITS{4'b1110}};
                        cursor_d = 3'(NUM_DIGITS - 1);
                    end
                end
            end
            ENTRY_INIT: state_d = ENTRY;
            ENTRY: begin
                // Priority next > back > move; one action per cycle.
                if (btn_edge[1]) begin
                    if (cursor_q == 3'd0) state_d = CHECK;
                    else cursor_d = cursor_q - 3'd1;
                end else if (btn_edge[0]) begin
                    if (cursor_q != 3'(NUM_DIGITS - 1)) cursor_d = cursor_q + 3'd1;
                end else if (btn_edge[2]) begin
                    // Rotating the one-hot-low nibble left walks the symbol cycle.
                    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                        if (cursor_q == 3'(k))
                            seq_d[4*k +: 4] = {seq_q[4*k+2 -: 3], seq_q[4*k+3]};
                    end
                end
            end
            CHECK: begin
                match_d = (seq_q == bus.sequence_in);
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        seg_c = '1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (state == SHOW)
                seg_c[7*k +: 7] = seg_map(bus.sequence_in[4*k +: 4]);
            else if (state != IDLE)
                seg_c[7*k +: 7] = seg_map(seq_q[4*k +: 4]);
        end
    end

    assign bus.sevseg       = seg_c;
    assign bus.sequence_out = seq_q;
    assign bus.cursor       = cursor_q;
    assign bus.done         = done_c;
    assign bus.match        = match_q;
endmodule

// File: tb/tb_seq_entry_display.sv
module tb_seq_entry_display;
    localparam int N  = 4;
    localparam int N6 = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_entry_display_if #(.NUM_DIGITS(N))  bus  ();
    seq_entry_display_if #(.NUM_DIGITS(N6)) bus6 ();

    seq_entry_display #(.NUM_DIGITS(N), .SHOW_SECONDS(2), .TRIGGER_CODE(8'h10)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    seq_entry_display #(.NUM_DIGITS(N6), .SHOW_SECONDS(2), .TRIGGER_CODE(8'h10)) dut6 (
        .clk(clk), .reset(reset), .bus(bus6)
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [4] = '{7'b1111110, 7'b1111001, 7'b1110111, 7'b1001111};

    // Reference model: symbol index per digit (0..3), cursor, phase flag.
    int          dig [8];
    int          cur;
    bit          in_entry;
    logic [15:0] tgt;

    typedef struct { logic [15:0] seq; logic m; } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] code_of(input int idx);
        return 4'hF & ~(4'd1 << idx);
    endfunction

    function automatic int sym_of(input logic [3:0] c);
        for (int i = 0; i < 4; i++) if (code_of(i) == c) return i;
        return -1;
    endfunction

    function automatic logic [63:0] exp_show(input logic [31:0] s, input int n);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < n; k++) begin
            int i;
            i = sym_of(s[4*k +: 4]);
            v[7*k +: 7] = (i < 0) ? 7'b0100001 : seg_tab[i];
        end
        return v;
    endfunction

    function automatic logic [15:0] model_seq();
        logic [15:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[4*k +: 4] = code_of(dig[k]);
        return v;
    endfunction

    function automatic logic [27:0] model_seg();
        logic [27:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[7*k +: 7] = seg_tab[dig[k]];
        return v;
    endfunction

    function automatic logic [15:0] rand_valid();
        logic [15:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[4*k +: 4] = code_of(int'($urandom_range(0, 3)));
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every done pulse consumes one expected completion.
    bit   pend   = 1'b0;
    logic pend_m = 1'b0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (pend) begin
            chk("match", 64'(bus.match), 64'(pend_m));
            pend = 1'b0;
        end
        if (bus.done === 1'b1) begin
            chk("done_single_cycle", 64'(prev_done), 64'(0));
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(bus.done), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_seq", 64'(bus.sequence_out), 64'(e.seq));
                pend   = 1'b1;
                pend_m = e.m;
            end
        end
        prev_done = bus.done;
    end

    task automatic check_entry_view(input string tag);
        chk({tag, "_cursor"}, 64'(bus.cursor), 64'(cur));
        chk({tag, "_seq"}, 64'(bus.sequence_out), 64'(model_seq()));
        chk({tag, "_seg"}, 64'(bus.sevseg), in_entry ? 64'(model_seg()) : 64'(28'hFFFFFFF));
    endtask

    task automatic press(input bit m, input bit n, input bit b, input int hold);
        bus.button_move = m;
        bus.button_next = n;
        bus.button_back = b;
        bus.one_sec     = 1'($urandom_range(0, 1));
        if (in_entry) begin
            if (n) begin
                if (cur == 0) begin
                    exp_t e;
                    e.seq = model_seq();
                    e.m   = (model_seq() == tgt);
                    sb.push_back(e);
                    in_entry = 1'b0;
                end else cur--;
            end else if (b) begin
                if (cur < N - 1) cur++;
            end else if (m) begin
                dig[cur] = (dig[cur] + 1) % 4;
            end
        end
        tick();
        bus.one_sec = 1'b0;
        repeat (hold - 1) tick();
        bus.button_move = 1'b0;
        bus.button_next = 1'b0;
        bus.button_back = 1'b0;
        tick();
        check_entry_view("press");
    endtask

    task automatic start_round(input logic [15:0] s);
        logic [15:0] alt;
        tgt = s;
        bus.sequence_in = s;
        bus.display = 8'h10;
        tick();
        bus.display = 8'($urandom_range(0, 255));
        if (bus.display == 8'h10) bus.display = 8'h00;
        chk("show_seg", exp_show(32'(s), N), 64'(bus.sevseg));
        for (int p = 0; p < 2; p++) begin
            repeat ($urandom_range(0, 3)) begin
                bus.button_move = 1'($urandom_range(0, 1));
                bus.button_next = 1'($urandom_range(0, 1));
                tick();
                bus.button_move = 1'b0;
                bus.button_next = 1'b0;
            end
            bus.one_sec = 1'b1;
            tick();
            bus.one_sec = 1'b0;
            if (p == 0) begin
                alt = 16'($urandom());
                bus.sequence_in = alt;
                tick();
                chk("show_live", 64'(bus.sevseg), exp_show(32'(alt), N));
                bus.sequence_in = s;
            end
        end
        for (int k = 0; k < 8; k++) dig[k] = 0;
        cur = N - 1;
        in_entry = 1'b1;
        check_entry_view("entry_init");
        tick();
    endtask

    task automatic enter(input logic [15:0] t, input int wrongk);
        while (cur < N - 1) press(1'b0, 1'b0, 1'b1, 1);
        for (int k = N - 1; k >= 0; k--) begin
            int want;
            want = sym_of(t[4*k +: 4]);
            if (want < 0) want = int'($urandom_range(0, 3));
            if (k == wrongk) want = (want + 1) % 4;
            while (dig[k] != want) press(1'b1, 1'b0, 1'b0, int'($urandom_range(1, 3)));
            if (k < N - 1 && $urandom_range(0, 3) == 0) begin
                press(1'b0, 1'b0, 1'b1, 1);
                press(1'b0, 1'b1, 1'b0, 1);
            end
            press(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)),
                  int'($urandom_range(1, 2)));
        end
        repeat (2) tick();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_seg"}, 64'(bus.sevseg), 64'(28'hFFFFFFF));
        chk({tag, "_seq"}, 64'(bus.sequence_out), 64'(16'hEEEE));
        chk({tag, "_cursor"}, 64'(bus.cursor), 64'(0));
        chk({tag, "_done"}, 64'(bus.done), 64'(0));
        chk({tag, "_match"}, 64'(bus.match), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] t;
        logic [23:0] s6;
        reset = 1'b0;
        bus.display = 8'h00;  bus.one_sec = 1'b0;  bus.sequence_in = '0;
        bus.button_move = 1'b1; bus.button_next = 1'b1; bus.button_back = 1'b0;
        bus6.display = 8'h00; bus6.one_sec = 1'b0; bus6.sequence_in = '0;
        bus6.button_move = 1'b0; bus6.button_next = 1'b0; bus6.button_back = 1'b0;
        for (int k = 0; k < 8; k++) dig[k] = 0;
        cur = 0; in_entry = 1'b0; tgt = '0;
        repeat (3) tick();
        bus.button_move = 1'b0; bus.button_next = 1'b0;
        tick();
        check_reset_state("reset");
        reset = 1'b1;
        tick();

        // Reference sequence: wrap, hold, back/next interplay, correct entry.
        start_round(16'h7BDE);
        press(1'b0, 1'b0, 1'b1, 1);
        repeat (5) press(1'b1, 1'b0, 1'b0, int'($urandom_range(1, 2)));
        chk("wrap_nibble3", 64'(bus.sequence_out[15:12]), 64'(4'b1101));
        chk("wrap_seg3", 64'(bus.sevseg[27:21]), 64'(7'b1111001));
        press(1'b1, 1'b0, 1'b0, 100);
        press(1'b0, 1'b1, 1'b0, 1);
        press(1'b0, 1'b0, 1'b1, 1);
        press(1'b1, 1'b1, 1'b0, 1);
        enter(16'h7BDE, -1);

        // Reset in the middle of an entry at cursor 1.
        start_round(rand_valid());
        press(1'b1, 1'b0, 1'b0, 1);
        press(1'b0, 1'b1, 1'b0, 1);
        press(1'b1, 1'b0, 1'b0, 2);
        press(1'b0, 1'b1, 1'b0, 1);
        chk("pre_reset_cursor", 64'(bus.cursor), 64'(1));
        reset = 1'b0;
        tick();
        check_reset_state("mid_reset");
        for (int k = 0; k < 8; k++) dig[k] = 0;
        cur = 0; in_entry = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        chk("post_reset_idle_seg", 64'(bus.sevseg), 64'(28'hFFFFFFF));

        // One wrong digit, then randomized rounds.
        t = rand_valid();
        start_round(t);
        enter(t, int'($urandom_range(0, N - 1)));
        for (int r = 0; r < 8; r++) begin
            t = rand_valid();
            if (r % 3 == 2) t[4*int'($urandom_range(0, N - 1)) +: 4] = 4'b0000;
            start_round(t);
            enter(t, (r % 2 == 1) ? int'($urandom_range(0, N - 1)) : -1);
        end

        // Six-digit instance: wider display, cursor starts at 5.
        s6 = '0;
        for (int k = 0; k < N6; k++) s6[4*k +: 4] = code_of(int'($urandom_range(0, 3)));
        bus6.sequence_in = s6;
        bus6.display = 8'h10;
        tick();
        bus6.display = 8'h00;
        chk("show6_seg", 64'(bus6.sevseg), exp_show(32'(s6), N6));
        repeat (2) begin
            bus6.one_sec = 1'b1;
            tick();
            bus6.one_sec = 1'b0;
            tick();
        end
        chk("entry6_seg", 64'(bus6.sevseg), 64'({N6{7'b1111110}}));
        chk("entry6_cursor", 64'(bus6.cursor), 64'(N6 - 1));
        chk("entry6_seq", 64'(bus6.sequence_out), 64'(24'hEEEEEE));

        repeat (3) tick();
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_entry_display.md
SEQ_ENTRY_DISPLAY -- requirements
Module: seq_entry_display

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of sequence digits and displays (range 2..8).
REQ-002 Parameter SHOW_SECONDS, default 2, one_sec pulses counted while the target sequence is shown (range 1..15).
REQ-003 Parameter TRIGGER_CODE, default 8'h10, value of display that starts a round.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 display  input  8  round selector; a round starts when it equals TRIGGER_CODE.
REQ-007 one_sec  input  1  single-cycle pulse, once per second.
REQ-008 sequence_in  input  4*NUM_DIGITS  target sequence; nibble k is a one-hot-low symbol code for digit k.
REQ-009 button_move, button_next, button_back  input  1 each  debounced level buttons, active-high.
REQ-010 sevseg  output  7*NUM_DIGITS  active-low segment patterns; bits [7k+6:7k] drive digit k.
REQ-011 sequence_out  output  4*NUM_DIGITS  entered sequence, same nibble encoding as sequence_in.
REQ-012 cursor  output  3  index of the digit currently being edited.
REQ-013 done  output  1  single-cycle pulse when entry completes.
REQ-014 match  output  1  registered; 1 when the completed entry equals sequence_in.

Function
REQ-015 Symbol map: 4'b1110->7'b1111110, 4'b1101->7'b1111001, 4'b1011->7'b1110111, 4'b0111->7'b1001111, any other code->7'b0100001 (error); blank is 7'b1111111.
REQ-016 Each button is rising-edge detected internally; one action per press, regardless of hold duration.
REQ-017 FSM states: IDLE, SHOW, ENTRY_INIT, ENTRY, CHECK.
REQ-018 IDLE: all digits blank, show counter 0; go to SHOW on the cycle after display==TRIGGER_CODE is sampled.
REQ-019 SHOW: every digit k shows the map of sequence_in nibble k, live each cycle; the counter increments on each one_sec pulse; after the cycle in which the counter reaches SHOW_SECONDS, go to ENTRY_INIT.
REQ-020 ENTRY_INIT (1 cycle): all digits 7'b1111110, every nibble of sequence_out 4'b1110, cursor=NUM_DIGITS-1, go to ENTRY.
REQ-021 ENTRY, move edge: the digit at cursor advances 1110->1101->1011->0111->1110 (wraps); its sevseg and nibble update together on the next cycle.
REQ-022 ENTRY, next edge: if cursor>0, decrement cursor; if cursor==0, go to CHECK.
REQ-023 ENTRY, back edge: if cursor<NUM_DIGITS-1, increment cursor; at NUM_DIGITS-1 it is ignored; entered values are preserved.
REQ-024 Simultaneous edges in the same cycle: priority is next, then back, then move; only one action is taken.
REQ-025 CHECK (1 cycle): match<=(sequence_out==sequence_in); done=1 for this cycle; go to IDLE. sevseg and sequence_out hold their values until the next ENTRY_INIT, except that IDLE blanks sevseg.
REQ-026 match holds until the next CHECK, or until reset.
REQ-027 Buttons are ignored outside ENTRY; one_sec is ignored outside SHOW.
REQ-028 display changing away from TRIGGER_CODE after the round has started has no effect.

Reset
REQ-029 When reset==0 at a clock edge, in any state: state=IDLE, sevseg all 7'b1111111, sequence_out all 4'b1110, cursor=0, done=0, match=0, show counter 0, edge-detector history cleared to 0.
REQ-030 Reset mid-entry discards the partial sequence; no done pulse is produced.

Verification
REQ-031 With NUM_DIGITS=4, sequence_in=16'h7BDE and display=8'h10: sevseg shows digits 0..3 as 1111110, 1111001, 1110111, 1001111; the 2nd one_sec pulse -> ENTRY with all digits 1111110 and cursor=3.
REQ-032 In ENTRY with cursor=3, press move 5 times -> digit 3 wraps to 4'b1101/7'b1111001; digits 0..2 are unchanged.
REQ-033 Enter 7,B,D,E on digits 3..0, then press next 4 times -> done pulses for exactly 1 cycle and match=1; a single wrong digit -> match=0.
REQ-034 At cursor=3, press back -> no change; next then back -> cursor returns to 3 with its value retained; next and move in the same cycle -> only the cursor moves.
REQ-035 Hold move for 100 cycles -> exactly one advance.
REQ-036 Assert reset during ENTRY at cursor=1 -> all outputs take their REQ-029 values on the next cycle, no done pulse; with NUM_DIGITS=6, the flow of REQ-031 produces a 42-bit sevseg and cursor starts at 5.
